// File: rtl/ibex_pkg.sv
// Shared definitions for the writeback scheduler.
//   RegAddrW : architectural register address width
//   wb_src_e : source of the value held in the write stage (debug/assertions)
package ibex_pkg;

    localparam int unsigned RegAddrW = 5;

    typedef enum logic [1:0] {
        WbNone = 2'd0,
        WbAlu  = 2'd1,
        WbLoad = 2'd2
    } wb_src_e;

endpackage

// File: rtl/ibex_wb_ldq.sv
// In-order FIFO of outstanding load destinations.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   push_i         : enqueue push_addr_i (caller guarantees not full)
//   pop_i          : dequeue head (caller guarantees not empty)
//   head_o         : destination of the oldest outstanding load
//   count_o        : number of valid entries
//   entry_valid_o  : per-slot valid, for hazard compare
//   entry_addr_o   : per-slot destination, for hazard compare
module ibex_wb_ldq
    import ibex_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               push_i,
    input  logic [RegAddrW-1:0]                push_addr_i,
    input  logic                               pop_i,
    output logic [RegAddrW-1:0]                head_o,
    output logic [$clog2(Depth):0]             count_o,
    output logic [Depth-1:0]                   entry_valid_o,
    output logic [Depth-1:0][RegAddrW-1:0]     entry_addr_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Depth-1:0][RegAddrW-1:0] mem_q;
    logic [PtrW-1:0]                wr_ptr_q;
    logic [PtrW-1:0]                rd_ptr_q;
    logic [CntW-1:0]                count_q;
    logic [PtrW-1:0]                offset;

    // Storage, pointers (wrap naturally since Depth is a power of two) and count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_addr_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the count
    always_comb begin
        entry_valid_o = '0;
        offset        = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            offset           = PtrW'(i) - rd_ptr_q;
            entry_valid_o[i] = CntW'(offset) < count_q;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign entry_addr_o = mem_q;

endmodule

// File: rtl/ibex_rf_wb_sched.sv
// Writeback scheduler for the register file write port. Merges ALU results
// and in-order load responses into one registered write stream and flags
// read-after-write hazards for the ID stage.
// Ports:
//   ex_*            : ALU result handshake (ex_ready_o low while a load response owns the port)
//   ld_issue_*      : load issue into the destination queue
//   ld_rvalid/rdata/err : load response for the oldest outstanding load
//   raddr_a/b, hazard_a/b : ID-stage read addresses and pending-write flags
//   rf_waddr/wdata/we : registered write to the register file
//   ld_pending_o    : outstanding load count
//   ld_spurious_o   : pulse one cycle after a response arrived with nothing outstanding
module ibex_rf_wb_sched
    import ibex_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LoadDepth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ex_valid_i,
    input  logic [RegAddrW-1:0]          ex_waddr_i,
    input  logic [DataWidth-1:0]         ex_wdata_i,
    output logic                         ex_ready_o,
    input  logic                         ld_issue_i,
    input  logic [RegAddrW-1:0]          ld_waddr_i,
    output logic                         ld_issue_ready_o,
    input  logic                         ld_rvalid_i,
    input  logic [DataWidth-1:0]         ld_rdata_i,
    input  logic                         ld_err_i,
    input  logic [RegAddrW-1:0]          raddr_a_i,
    input  logic [RegAddrW-1:0]          raddr_b_i,
    output logic                         hazard_a_o,
    output logic                         hazard_b_o,
    output logic [RegAddrW-1:0]          rf_waddr_o,
    output logic [DataWidth-1:0]         rf_wdata_o,
    output logic                         rf_we_o,
    output logic [$clog2(LoadDepth):0]   ld_pending_o,
    output logic                         ld_spurious_o
);

    localparam int unsigned CntW = $clog2(LoadDepth) + 1;

    logic [RegAddrW-1:0]                 ld_head;
    logic [CntW-1:0]                     ld_count;
    logic [LoadDepth-1:0]                ld_valid;
    logic [LoadDepth-1:0][RegAddrW-1:0]  ld_addr;
    logic                                ld_push;
    logic                                ld_pop;
    logic                                ld_wr;
    logic                                alu_wr;
    wb_src_e                             wb_src_q;

    // x0 is never written; under RV32E neither is anything above x15
    function automatic logic writable(input logic [RegAddrW-1:0] a);
        return (a != '0) && !(RV32E && a[RegAddrW-1]);
    endfunction

    ibex_wb_ldq #(
        .Depth (LoadDepth)
    ) u_ldq (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (ld_push),
        .push_addr_i   (ld_waddr_i),
        .pop_i         (ld_pop),
        .head_o        (ld_head),
        .count_o       (ld_count),
        .entry_valid_o (ld_valid),
        .entry_addr_o  (ld_addr)
    );

    // Issue readiness uses the registered count only, so a full queue refuses
    // an issue even when a response frees a slot in the same cycle
    assign ld_issue_ready_o = ld_count != CntW'(LoadDepth);
    assign ld_push          = ld_issue_i & ld_issue_ready_o;
    assign ld_pop           = ld_rvalid_i & (ld_count != '0);
    assign ex_ready_o       = !ld_pop;
    assign ld_wr            = ld_pop & !ld_err_i & writable(ld_head);
    assign alu_wr           = ex_valid_i & ex_ready_o & writable(ex_waddr_i);
    assign ld_pending_o     = ld_count;

    // Write stage: one cycle of rf_we_o per accepted write; addr/data hold otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_waddr_o    <= '0;
            rf_wdata_o    <= '0;
            rf_we_o       <= 1'b0;
            wb_src_q      <= WbNone;
            ld_spurious_o <= 1'b0;
        end else begin
            ld_spurious_o <= ld_rvalid_i & (ld_count == '0);
            if (ld_wr) begin
                rf_waddr_o <= ld_head;
                rf_wdata_o <= ld_rdata_i;
                rf_we_o    <= 1'b1;
                wb_src_q   <= WbLoad;
            end else if (alu_wr) begin
                rf_waddr_o <= ex_waddr_i;
                rf_wdata_o <= ex_wdata_i;
                rf_we_o    <= 1'b1;
                wb_src_q   <= WbAlu;
            end else begin
                rf_we_o    <= 1'b0;
                wb_src_q   <= WbNone;
            end
        end
    end

    // Hazard: pending load destination or value sitting in the write stage
    always_comb begin
        hazard_a_o = 1'b0;
        hazard_b_o = 1'b0;
        for (int unsigned i = 0; i < LoadDepth; i++) begin
            if (ld_valid[i] && (ld_addr[i] == raddr_a_i)) hazard_a_o = 1'b1;
            if (ld_valid[i] && (ld_addr[i] == raddr_b_i)) hazard_b_o = 1'b1;
        end
        if (rf_we_o && (rf_waddr_o == raddr_a_i)) hazard_a_o = 1'b1;
        if (rf_we_o && (rf_waddr_o == raddr_b_i)) hazard_b_o = 1'b1;
        if (raddr_a_i == '0) hazard_a_o = 1'b0;
        if (raddr_b_i == '0) hazard_b_o = 1'b0;
    end

    a_we_has_src: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rf_we_o |-> (wb_src_q != WbNone));

endmodule

// File: tb/tb_ibex_rf_wb_sched.sv
module tb_ibex_rf_wb_sched;

    localparam int DEPTH = 2;

    typedef struct {
        logic        exv;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        iss;
        logic [4:0]  isa;
        logic        rv;
        logic [31:0] rd;
        logic        err;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        exr;
        logic        isr;
        logic        ha;
        logic        hb;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  cnt;
        logic        sp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [4:0]  ex_waddr_i = '0;
    logic [31:0] ex_wdata_i = '0;
    logic        ld_issue_i = 1'b0;
    logic [4:0]  ld_waddr_i = '0;
    logic        ld_rvalid_i = 1'b0;
    logic [31:0] ld_rdata_i = '0;
    logic        ld_err_i = 1'b0;
    logic [4:0]  raddr_a_i = '0;
    logic [4:0]  raddr_b_i = '0;

    logic        ex_ready_o, ld_issue_ready_o, hazard_a_o, hazard_b_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_we_o, ld_spurious_o;
    logic [1:0]  ld_pending_o;

    logic        e_ex_ready, e_issue_ready, e_haz_a, e_haz_b;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_we, e_spurious;
    logic [1:0]  e_pending;

    int checks = 0;
    int failures = 0;

    // Reference model state: queue of outstanding destinations plus write stage
    logic [4:0]  mq[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    always #5 clk_i = ~clk_i;

    ibex_rf_wb_sched #(.RV32E(1'b0), .DataWidth(32), .LoadDepth(DEPTH)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
        .ld_issue_i(ld_issue_i), .ld_waddr_i(ld_waddr_i), .ld_issue_ready_o(ld_issue_ready_o),
        .ld_rvalid_i(ld_rvalid_i), .ld_rdata_i(ld_rdata_i), .ld_err_i(ld_err_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
        .ld_pending_o(ld_pending_o), .ld_spurious_o(ld_spurious_o)
    );

    ibex_rf_wb_sched #(.RV32E(1'b1), .DataWidth(32), .LoadDepth(DEPTH)) u_dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(e_ex_ready),
        .ld_issue_i(ld_issue_i), .ld_waddr_i(ld_waddr_i), .ld_issue_ready_o(e_issue_ready),
        .ld_rvalid_i(ld_rvalid_i), .ld_rdata_i(ld_rdata_i), .ld_err_i(ld_err_i),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .hazard_a_o(e_haz_a), .hazard_b_o(e_haz_b),
        .rf_waddr_o(e_waddr), .rf_wdata_o(e_wdata), .rf_we_o(e_we),
        .ld_pending_o(e_pending), .ld_spurious_o(e_spurious)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic exv, input logic [4:0] exa, input logic [31:0] exd,
        input logic iss, input logic [4:0] isa,
        input logic rv, input logic [31:0] rd, input logic err,
        input logic [4:0] ra, input logic [4:0] rb,
        input logic exr, input logic isr, input logic ha, input logic hb,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [1:0] cnt, input logic sp);
        vec_t v;
        v.exv = exv; v.exa = exa; v.exd = exd; v.iss = iss; v.isa = isa;
        v.rv = rv; v.rd = rd; v.err = err; v.ra = ra; v.rb = rb;
        v.exr = exr; v.isr = isr; v.ha = ha; v.hb = hb;
        v.we = we; v.wa = wa; v.wd = wd; v.cnt = cnt; v.sp = sp;
        return v;
    endfunction

    function automatic logic m_writable(input logic [4:0] a);
        return a != 5'd0;
    endfunction

    function automatic logic m_hazard(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[k]) if (mq[k] == r) return 1'b1;
        return m_we && (m_wa == r);
    endfunction

    // Fills in expectations from the architectural rules and advances the model
    function automatic void model_step(inout vec_t v);
        int  n;
        logic pop;
        logic [4:0] h;
        n     = mq.size();
        pop   = v.rv && (n > 0);
        v.isr = (n != DEPTH);
        v.exr = !pop;
        v.ha  = m_hazard(v.ra);
        v.hb  = m_hazard(v.rb);
        m_we  = 1'b0;
        if (pop) begin
            h = mq[0];
            if (!v.err && m_writable(h)) begin
                m_we = 1'b1; m_wa = h; m_wd = v.rd;
            end
        end else if (v.exv && m_writable(v.exa)) begin
            m_we = 1'b1; m_wa = v.exa; m_wd = v.exd;
        end
        v.sp = v.rv && (n == 0);
        if (pop) void'(mq.pop_front());
        if (v.iss && (n != DEPTH)) mq.push_back(v.isa);
        v.we  = m_we;
        v.wa  = m_wa;
        v.wd  = m_wd;
        v.cnt = 2'(mq.size());
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endfunction

    task automatic drive(input vec_t v);
        ex_valid_i = v.exv; ex_waddr_i = v.exa; ex_wdata_i = v.exd;
        ld_issue_i = v.iss; ld_waddr_i = v.isa;
        ld_rvalid_i = v.rv; ld_rdata_i = v.rd; ld_err_i = v.err;
        raddr_a_i = v.ra; raddr_b_i = v.rb;
    endtask

    // One cycle: drive, check combinational outputs, clock, check registered outputs
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        #1;
        chk({tag, " ex_ready"},    ex_ready_o,       v.exr);
        chk({tag, " issue_ready"}, ld_issue_ready_o, v.isr);
        chk({tag, " hazard_a"},    hazard_a_o,       v.ha);
        chk({tag, " hazard_b"},    hazard_b_o,       v.hb);
        @(posedge clk_i);
        #1;
        chk({tag, " rf_we"},       rf_we_o,          v.we);
        chk({tag, " rf_waddr"},    rf_waddr_o,       v.wa);
        chk({tag, " rf_wdata"},    rf_wdata_o,       v.wd);
        chk({tag, " ld_pending"},  ld_pending_o,     v.cnt);
        chk({tag, " spurious"},    ld_spurious_o,    v.sp);
    endtask

    function automatic vec_t idle();
        return mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
    endfunction

    task automatic reset_all();
        drive(idle());
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
    endtask

    vec_t tbl[15];
    vec_t v;

    initial begin
        // Directed sequences: ALU write, collision, queue full, error/x0, spurious
        tbl[0]  = mk(1,5,32'hDEADBEEF,0,0,0,0,0,0,0, 1,1,0,0, 1,5,32'hDEADBEEF,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,0,0,5,3,           1,1,1,0, 0,5,32'hDEADBEEF,0,0);
        tbl[2]  = mk(0,0,0,1,7,0,0,0,7,0,           1,1,0,0, 0,5,32'hDEADBEEF,1,0);
        tbl[3]  = mk(1,3,32'h55,0,0,1,32'h1234,0,7,3, 0,1,1,0, 1,7,32'h1234,0,0);
        tbl[4]  = mk(1,3,32'h55,0,0,0,0,0,7,3,      1,1,1,0, 1,3,32'h55,0,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,0,3,0,           1,1,1,0, 0,3,32'h55,0,0);
        tbl[6]  = mk(0,0,0,1,1,0,0,0,1,0,           1,1,0,0, 0,3,32'h55,1,0);
        tbl[7]  = mk(0,0,0,1,2,0,0,0,1,2,           1,1,1,0, 0,3,32'h55,2,0);
        tbl[8]  = mk(0,0,0,1,4,1,32'hAAAA,0,2,4,    0,0,1,0, 1,1,32'hAAAA,1,0);
        tbl[9]  = mk(0,0,0,0,0,1,32'hBBBB,0,2,1,    0,1,1,1, 1,2,32'hBBBB,0,0);
        tbl[10] = mk(0,0,0,1,0,0,0,0,0,2,           1,1,0,1, 0,2,32'hBBBB,1,0);
        tbl[11] = mk(0,0,0,1,9,1,32'hCCCC,0,9,0,    0,1,0,0, 0,2,32'hBBBB,1,0);
        tbl[12] = mk(0,0,0,0,0,1,32'hDDDD,1,9,0,    0,1,1,0, 0,2,32'hBBBB,0,0);
        tbl[13] = mk(0,0,0,0,0,1,32'hEEEE,0,0,0,    1,1,0,0, 0,2,32'hBBBB,0,1);
        tbl[14] = mk(0,0,0,0,0,0,0,0,0,0,           1,1,0,0, 0,2,32'hBBBB,0,0);

        // Reset values with idle inputs and a nonzero read address
        drive(idle());
        raddr_a_i = 5'd5;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset rf_we",       rf_we_o,          1'b0);
        chk("reset rf_waddr",    rf_waddr_o,       5'd0);
        chk("reset rf_wdata",    rf_wdata_o,       32'd0);
        chk("reset ld_pending",  ld_pending_o,     2'd0);
        chk("reset spurious",    ld_spurious_o,    1'b0);
        chk("reset issue_ready", ld_issue_ready_o, 1'b1);
        chk("reset ex_ready",    ex_ready_o,       1'b1);
        chk("reset hazard_a",    hazard_a_o,       1'b0);
        rst_ni = 1'b1;
        model_reset();

        for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Randomised traffic against the reference model
        reset_all();
        for (int i = 0; i < 1500; i++) begin
            v = idle();
            v.exv = 1'($urandom_range(0, 1));
            v.exa = 5'($urandom_range(0, 7));
            v.exd = $urandom;
            v.iss = 1'($urandom_range(0, 1));
            v.isa = 5'($urandom_range(0, 7));
            v.rv  = ($urandom_range(0, 2) == 0);
            v.rd  = $urandom;
            v.err = ($urandom_range(0, 7) == 0);
            v.ra  = 5'($urandom_range(0, 7));
            v.rb  = 5'($urandom_range(0, 7));
            model_step(v);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset with two loads outstanding
        reset_all();
        v = idle(); v.iss = 1'b1; v.isa = 5'd3; model_step(v); run_vec(v, "mid_iss3");
        v = idle(); v.iss = 1'b1; v.isa = 5'd6; model_step(v); run_vec(v, "mid_iss6");
        v = idle(); v.ra = 5'd3; v.rb = 5'd6;
        drive(v);
        #1;
        chk("mid pre hazard_a", hazard_a_o,   1'b1);
        chk("mid pre hazard_b", hazard_b_o,   1'b1);
        chk("mid pre pending",  ld_pending_o, 2'd2);
        rst_ni = 1'b0;
        #1;
        chk("mid rst pending",     ld_pending_o,     2'd0);
        chk("mid rst hazard_a",    hazard_a_o,       1'b0);
        chk("mid rst hazard_b",    hazard_b_o,       1'b0);
        chk("mid rst issue_ready", ld_issue_ready_o, 1'b1);
        chk("mid rst rf_we",       rf_we_o,          1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
        v = idle(); v.rv = 1'b1; v.rd = 32'h77; model_step(v); run_vec(v, "post_rst_resp");
        v = idle(); model_step(v); run_vec(v, "post_rst_idle");

        // RV32E: high register accepted but not written; low register written
        v = idle(); v.exv = 1'b1; v.exa = 5'd20; v.exd = 32'h2020; model_step(v);
        drive(v);
        #1;
        chk("rv32e x20 ex_ready", e_ex_ready, 1'b1);
        run_vec(v, "rv32e_x20_main");
        chk("rv32e x20 rf_we", e_we, 1'b0);
        v = idle(); v.exv = 1'b1; v.exa = 5'd10; v.exd = 32'h1010; model_step(v);
        run_vec(v, "rv32e_x10_main");
        chk("rv32e x10 rf_we",    e_we,    1'b1);
        chk("rv32e x10 rf_waddr", e_waddr, 5'd10);
        chk("rv32e x10 rf_wdata", e_wdata, 32'h1010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
